// File: rtl/result_reporter_if.sv
// Miner-result and byte-stream signals of the result reporter, grouped as one bundle.
// The slave side is the reporter itself; the master side is whatever feeds it and drains it.
interface result_reporter_if;
    logic        nonce_found;
    logic [31:0] nonce_out;
    logic [31:0] hash_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        overflow;
    logic        overflow_clr;
    logic [15:0] found_count;

    modport master (
        output nonce_found, nonce_out, hash_out, tx_ready, overflow_clr,
        input  tx_data, tx_valid, overflow, found_count
    );

    modport slave (
        input  nonce_found, nonce_out, hash_out, tx_ready, overflow_clr,
        output tx_data, tx_valid, overflow, found_count
    );
endinterface

// File: rtl/result_reporter.sv
// Queues miner results in a small FIFO and serialises each one as a 10-byte
// frame (sync, nonce, hash, XOR checksum) over a valid/ready byte stream.
module result_reporter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    result_reporter_if.slave bus
);
    localparam int unsigned   AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned   CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_IDX = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic logic [7:0] payload_xor(input logic [63:0] payload);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ payload[i*8 +: 8];
        end
        return acc;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [63:0] payload, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = SYNC_BYTE;
            4'd1:    b = payload[63:56];
            4'd2:    b = payload[55:48];
            4'd3:    b = payload[47:40];
            4'd4:    b = payload[39:32];
            4'd5:    b = payload[31:24];
            4'd6:    b = payload[23:16];
            4'd7:    b = payload[15:8];
            4'd8:    b = payload[7:0];
            4'd9:    b = payload_xor(payload);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [63:0]   frame_q, frame_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   found_q, found_d;

    logic pop_s;
    logic push_s;
    logic drop_s;
    logic xfer_s;

    // A full FIFO still accepts a push when the same edge pops an entry.
    assign pop_s  = (state_q == ST_IDLE) && (count_q != {CW{1'b0}});
    assign push_s = bus.nonce_found && ((count_q != FULL_CNT) || pop_s);
    assign drop_s = bus.nonce_found && !push_s;
    assign xfer_s = tx_valid_q && bus.tx_ready;

    // FIFO pointer, occupancy, sticky overflow and saturating found counter next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        found_d    = found_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase

        // A drop on the clearing edge wins so the loss is never hidden.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (bus.overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (bus.nonce_found && (found_q != 16'hFFFF)) begin
            found_d = found_q + 16'd1;
        end else begin
            found_d = found_q;
        end
    end

    // Frame FSM next-state; outputs are computed from the next state so they can be registered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;

        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_SEND;
                    idx_d   = 4'd0;
                    frame_d = mem_q[rd_ptr_q];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (xfer_s) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end
        endcase

        tx_valid_d = (state_d == ST_SEND);
        if (tx_valid_d) begin
            tx_data_d = frame_byte(frame_d, idx_d);
        end else begin
            tx_data_d = 8'h00;
        end
    end

    // Result storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.nonce_out, bus.hash_out};
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            frame_q    <= 64'h0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            found_q    <= 16'h0000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
            found_q    <= found_d;
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.overflow    = overflow_q;
    assign bus.found_count = found_q;
endmodule

// File: tb/tb_result_reporter.sv
// Self-checking bench for result_reporter: randomized results and backpressure
// checked against a queue-level model of the framing rules.
module tb_result_reporter;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    result_reporter_if ifc ();

    result_reporter #(.FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: pending results, expected byte stream, sender occupancy.
    logic [63:0] m_q [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  act_q [$];
    bit          m_busy;
    int          m_left;
    logic        m_ovf;
    logic [15:0] m_found;
    bit          last_valid;
    bit          last_rdy;
    logic [7:0]  last_data;
    int          stall_bad;

    function automatic void flush_model();
        m_q.delete();
        exp_q.delete();
        act_q.delete();
        m_busy     = 1'b0;
        m_left     = 0;
        m_ovf      = 1'b0;
        m_found    = 16'h0000;
        last_valid = 1'b0;
        last_rdy   = 1'b0;
        last_data  = 8'h00;
        stall_bad  = 0;
    endfunction

    function automatic void add_frame(input logic [63:0] fr);
        logic [7:0] ck;
        ck = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(fr[i*8 +: 8]);
            ck = ck ^ fr[i*8 +: 8];
        end
        exp_q.push_back(ck);
    endfunction

    function automatic int stream_diff();
        if (act_q.size() != exp_q.size()) return -2;
        foreach (act_q[i]) begin
            if (act_q[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    // One clock: drive inputs at the falling edge, record transfers, advance the model.
    task automatic cycle(input logic f, input logic [31:0] n, input logic [31:0] h,
                         input logic rdy, input logic clr);
        bit pop_now;
        bit drop;
        if (last_valid && !last_rdy && (ifc.tx_valid !== 1'b1 || ifc.tx_data !== last_data))
            stall_bad++;
        ifc.nonce_found  = f;
        ifc.nonce_out    = n;
        ifc.hash_out     = h;
        ifc.tx_ready     = rdy;
        ifc.overflow_clr = clr;
        if (ifc.tx_valid === 1'b1 && rdy) act_q.push_back(ifc.tx_data);
        last_valid = (ifc.tx_valid === 1'b1);
        last_data  = ifc.tx_data;
        last_rdy   = rdy;

        pop_now = !m_busy && (m_q.size() > 0);
        if (m_busy && rdy) begin
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
        end
        if (pop_now) begin
            add_frame(m_q.pop_front());
            m_busy = 1'b1;
            m_left = 10;
        end
        drop = 1'b0;
        if (f) begin
            if (m_q.size() < DEPTH) m_q.push_back({n, h});
            else drop = 1'b1;
            if (m_found != 16'hFFFF) m_found++;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int mode, output bit timed_out);
        logic rdy;
        timed_out = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            if (!m_busy && m_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((k % 4) == 0) || ((k % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0);
        end
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        ifc.nonce_found  = 1'b0;
        ifc.tx_ready     = 1'b0;
        ifc.overflow_clr = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        flush_model();
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        ifc.nonce_found  = 1'b1;
        ifc.nonce_out    = $urandom;
        ifc.hash_out     = $urandom;
        ifc.tx_ready     = 1'b1;
        ifc.overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (ifc.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", ifc.tx_valid); end
        n_tests++; if (ifc.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", ifc.tx_data); end
        n_tests++; if (ifc.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", ifc.overflow); end
        n_tests++; if (ifc.found_count !== 16'h0000) begin n_fail++; $display("FAIL reset_found_count: got %h want 0000", ifc.found_count); end
        ifc.nonce_found = 1'b0;
        reset = 1'b1;
        flush_model();
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_tests++; if (act_q.size() != 0) begin n_fail++; $display("FAIL reset_no_frame: got %0d bytes want 0", act_q.size()); end
    endtask

    task automatic test_single_frame();
        logic [7:0] golden [10];
        bit to;
        golden = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'h6E};
        do_reset();
        cycle(1'b1, 32'h12345678, 32'h0000ABCD, 1'b1, 1'b0);
        n_tests++; if (ifc.tx_valid !== 1'b0) begin n_fail++; $display("FAIL latency_n1: tx_valid %b want 0", ifc.tx_valid); end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_tests++; if (ifc.tx_valid !== 1'b1 || ifc.tx_data !== 8'hA5) begin
            n_fail++; $display("FAIL latency_n2: valid %b data %h want 1 a5", ifc.tx_valid, ifc.tx_data);
        end
        drain(0, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL single_drain: timeout got 1 want 0"); end
        n_tests++; if (act_q.size() != 10) begin
            n_fail++; $display("FAIL single_len: got %0d bytes want 10", act_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (act_q[i] !== golden[i]) begin
                    n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, act_q[i], golden[i]);
                end
            end
        end
        n_tests++; if (ifc.found_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", ifc.found_count); end
    endtask

    task automatic test_backpressure();
        logic [7:0] golden [10];
        bit to;
        golden = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'h6E};
        do_reset();
        cycle(1'b1, 32'h12345678, 32'h0000ABCD, 1'b1, 1'b0);
        drain(1, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL bp_drain: timeout got 1 want 0"); end
        n_tests++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable stall cycles want 0", stall_bad); end
        n_tests++; if (act_q.size() != 10) begin
            n_fail++; $display("FAIL bp_len: got %0d bytes want 10", act_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (act_q[i] !== golden[i]) begin
                    n_fail++; $display("FAIL bp_byte%0d: got %h want %h", i, act_q[i], golden[i]);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        int vbad;
        int d;
        bit to;
        do_reset();
        vbad = 0;
        for (int i = 0; i < 120; i++) begin
            cycle(1'($urandom_range(0, 3) == 0), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            if (ifc.tx_valid !== m_busy) vbad++;
        end
        n_tests++; if (vbad != 0) begin n_fail++; $display("FAIL rand_valid_timing: %0d bad cycles want 0", vbad); end
        n_tests++; if (ifc.overflow !== m_ovf) begin n_fail++; $display("FAIL rand_overflow: got %b want %b", ifc.overflow, m_ovf); end
        n_tests++; if (ifc.found_count !== m_found) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", ifc.found_count, m_found); end
        drain(2, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL rand_drain: timeout got 1 want 0"); end
        n_tests++; if (stall_bad != 0) begin n_fail++; $display("FAIL rand_stable: %0d unstable stall cycles want 0", stall_bad); end
        d = stream_diff();
        n_tests++; if (d != -1) begin
            n_fail++; $display("FAIL rand_stream: got %0d bytes want %0d, first diff %0d", act_q.size(), exp_q.size(), d);
        end
    endtask

    task automatic test_burst_overflow();
        int d;
        bit to;
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        n_tests++; if (ifc.overflow !== 1'b1) begin n_fail++; $display("FAIL burst_overflow: got %b want 1", ifc.overflow); end
        n_tests++; if (ifc.found_count !== 16'd6) begin n_fail++; $display("FAIL burst_count: got %0d want 6", ifc.found_count); end
        drain(0, to);
        n_tests++; if (act_q.size() != 50) begin n_fail++; $display("FAIL burst_len: got %0d bytes want 50", act_q.size()); end
        d = stream_diff();
        n_tests++; if (d != -1) begin
            n_fail++; $display("FAIL burst_stream: got %0d bytes want %0d, first diff %0d", act_q.size(), exp_q.size(), d);
        end
    endtask

    task automatic test_full_push_pop();
        int d;
        bit to;
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        for (int k = 0; k < 100 && m_busy; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0);
        n_tests++; if (ifc.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp_overflow: got %b want 0", ifc.overflow); end
        drain(0, to);
        n_tests++; if (act_q.size() != 60) begin n_fail++; $display("FAIL fullpp_len: got %0d bytes want 60", act_q.size()); end
        d = stream_diff();
        n_tests++; if (d != -1) begin
            n_fail++; $display("FAIL fullpp_stream: got %0d bytes want %0d, first diff %0d", act_q.size(), exp_q.size(), d);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0);
        for (int k = 0; k < 30 && act_q.size() < 4; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        n_tests++; if (ifc.tx_valid !== 1'b0 || ifc.tx_data !== 8'h00) begin
            n_fail++; $display("FAIL midreset_outputs: valid %b data %h want 0 00", ifc.tx_valid, ifc.tx_data);
        end
        n_tests++; if (ifc.found_count !== 16'h0 || ifc.overflow !== 1'b0) begin
            n_fail++; $display("FAIL midreset_status: count %0d ovf %b want 0 0", ifc.found_count, ifc.overflow);
        end
        flush_model();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_tests++; if (act_q.size() != 0 || ifc.tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_quiet: got %0d bytes valid %b want 0 0", act_q.size(), ifc.tx_valid);
        end
    endtask

    task automatic test_saturation_clear();
        bit to;
        do_reset();
        for (int i = 0; i < 65537; i++) cycle(1'b1, 32'(i), ~32'(i), 1'b0, 1'b0);
        n_tests++; if (ifc.found_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count: got %h want ffff", ifc.found_count); end
        n_tests++; if (ifc.overflow !== 1'b1) begin n_fail++; $display("FAIL sat_overflow: got %b want 1", ifc.overflow); end
        cycle(1'b1, 32'h1, 32'h2, 1'b0, 1'b1);
        n_tests++; if (ifc.overflow !== 1'b1) begin n_fail++; $display("FAIL clr_with_drop: got %b want 1", ifc.overflow); end
        n_tests++; if (ifc.found_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", ifc.found_count); end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        n_tests++; if (ifc.overflow !== 1'b0) begin n_fail++; $display("FAIL clr_plain: got %b want 0", ifc.overflow); end
        drain(0, to);
        n_tests++; if (to || stream_diff() != -1) begin
            n_fail++; $display("FAIL sat_stream: got %0d bytes want %0d", act_q.size(), exp_q.size());
        end
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        reset            = 1'b0;
        ifc.nonce_found  = 1'b0;
        ifc.nonce_out    = 32'h0;
        ifc.hash_out     = 32'h0;
        ifc.tx_ready     = 1'b0;
        ifc.overflow_clr = 1'b0;
        flush_model();
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_backpressure();
        test_random_stream();
        test_burst_overflow();
        test_full_push_pop();
        test_reset_mid_frame();
        test_saturation_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
